// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo: default sizes, pointer/count width helpers and pointer wrap.
package sync_fifo_pkg;

  typedef int unsigned idx_t;

  localparam idx_t DEFAULT_DEPTH = 8;
  localparam idx_t DEFAULT_WIDTH = 8;

  // Address width for a DEPTH-entry array.
  function automatic idx_t ptr_width(idx_t depth);
    return idx_t'($clog2(depth));
  endfunction

  // Width able to hold the values 0..DEPTH.
  function automatic idx_t cnt_width(idx_t depth);
    return idx_t'($clog2(depth + 1));
  endfunction

  // DEPTH need not be a power of two, so the pointer wraps explicitly.
  function automatic idx_t ptr_next(idx_t ptr, idx_t depth);
    return (ptr == depth - 1) ? idx_t'(0) : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array with a synchronous write port and an asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter idx_t DEPTH = DEFAULT_DEPTH,
  parameter idx_t WIDTH = DEFAULT_WIDTH,
  localparam idx_t ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the pointers and count, so clearing
  // it would only cost a reset net per bit and block mapping to plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always visible on read_data.
// Define SYNC_FIFO_LEVEL_EN to expose the fill count on an extra `level` output.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter idx_t DEPTH = DEFAULT_DEPTH,
  parameter idx_t WIDTH = DEFAULT_WIDTH,
  localparam idx_t PTR_W = ptr_width(DEPTH),
  localparam idx_t CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] write_data,
  output logic             full,
  output logic             empty,
`ifdef SYNC_FIFO_LEVEL_EN
  output logic [CNT_W-1:0] level,
`endif
  output logic [WIDTH-1:0] read_data
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_accept;
  logic             rd_accept;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A write while full is still taken when a read frees the head slot at the same edge.
  assign wr_accept = write && (!full || read);
  assign rd_accept = read && !empty;

`ifdef SYNC_FIFO_LEVEL_EN
  assign level = count_q;
`endif

  // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned
  // and no latch is inferred; blocking assignments are correct here because this is pure logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) begin
      wr_ptr_d = PTR_W'(ptr_next(idx_t'(wr_ptr_q), DEPTH));
    end
    if (rd_accept) begin
      rd_ptr_d = PTR_W'(ptr_next(idx_t'(rd_ptr_q), DEPTH));
    end
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (write_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (read_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue model predicts pops, a monitor compares them.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             write = 1'b0;
  logic             read = 1'b0;
  logic [WIDTH-1:0] write_data = '0;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] read_data;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [$clog2(DEPTH+1)-1:0] level;
`endif

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model_q [$];  // reference FIFO contents, head at index 0
  logic [WIDTH-1:0] sb_q    [$];  // expected values of accepted pops, in order

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .read       (read),
    .write_data (write_data),
    .full       (full),
    .empty      (empty),
`ifdef SYNC_FIFO_LEVEL_EN
    .level      (level),
`endif
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT flags and head against the model after an edge.
  task automatic check_state(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
    if (model_q.size() != 0) check({tag, ".head"}, 32'(read_data), 32'(model_q[0]));
`ifdef SYNC_FIFO_LEVEL_EN
    check({tag, ".level"}, 32'(level), 32'(model_q.size()));
`endif
  endtask

  // One clock with the given strobes; the model applies the acceptance rules.
  task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
    bit rd_ok, wr_ok;
    write      = w;
    read       = r;
    write_data = d;
    rd_ok = r && (model_q.size() != 0);
    wr_ok = w && ((model_q.size() < DEPTH) || r);
    if (rd_ok) sb_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    @(posedge clk);
    #1;
    write = 1'b0;
    read  = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input int n, input string tag);
    reset = 1'b1;
    write = 1'b0;
    read  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
    check_state(tag);
  endtask

  // Monitor: a pop is presented whenever read is high on a non-empty FIFO; sample mid-cycle.
  always @(negedge clk) begin
    if (!reset && read && !empty) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop: got unexpected pop 0x%0h expected no pop at %0t", read_data, $time);
      end else begin
        check("pop", 32'(read_data), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset for two cycles, then a read pulse on the empty FIFO must change nothing.
    @(posedge clk);
    #1;
    do_reset(2, "reset");
    cycle(1'b0, 1'b1, 8'h00, "read_empty");

    // Consecutive pushes then three single-cycle pops.
    cycle(1'b1, 1'b0, 8'h11, "push11");
    cycle(1'b1, 1'b0, 8'h22, "push22");
    cycle(1'b1, 1'b0, 8'h33, "push33");
    repeat (3) cycle(1'b0, 1'b1, 8'h00, "pop3");

    // Fill, overflow attempt, drain; three rounds move the pointers through the wrap.
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'hA0 + 8'(i), "fill");
      cycle(1'b1, 1'b0, 8'hFF, "overflow");
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, "drain");
    end

    // Simultaneous read and write while full.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'hA0 + 8'(i), "fill2");
    cycle(1'b1, 1'b1, 8'hB0, "rw_full");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, "drain2");

    // Simultaneous read and write while empty: only the write lands.
    cycle(1'b1, 1'b1, 8'h5A, "rw_empty");
    cycle(1'b0, 1'b1, 8'h00, "pop5a");

    // Reset with five entries held, then a push/pop round trip.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), "pre_reset");
    do_reset(1, "mid_reset");
    cycle(1'b1, 1'b0, 8'h77, "push77");
    cycle(1'b0, 1'b1, 8'h00, "pop77");

    // Randomised traffic with occasional biasing toward filling or draining.
    for (int i = 0; i < 400; i++) begin
      logic w, r;
      if (i % 100 < 30) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else if (i % 100 < 60) begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end else begin
        w = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      cycle(w, r, 8'($urandom), "random");
    end

    // Every predicted pop must have been observed by the monitor.
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
